switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//   Input-side companion to the LED/GPIO pattern drivers. Samples WIDTH
//   asynchronous board inputs (DIP switches, push buttons) and synchronises
//   and debounces them. Emits a clean level plus one-cycle rise/fall pulses
//   per bit, and a saturating press counter that other blocks can read.
// PARAMETERS
//   WIDTH        8      number of input bits
//   TICK_DIV     50000  clk cycles per debounce sample tick (>=2)
//   STABLE_TICKS 4      consecutive differing ticks needed to accept a new level (>=1)
//   COUNT_W      16     width of event_count
// PORTS
//   clk          in   1        system clock, all logic on posedge
//   rst          in   1        synchronous, active-high reset
//   sw_in        in   WIDTH    raw asynchronous inputs
//   clear_count  in   1        synchronous clear of event_count
//   sw_state     out  WIDTH    debounced level
//   sw_rise      out  WIDTH    1-cycle pulse, bit accepted 0->1
//   sw_fall      out  WIDTH    1-cycle pulse, bit accepted 1->0
//   any_change   out  1        |(sw_rise|sw_fall), same cycle
//   event_count  out  COUNT_W  cycles with any rise, saturating
// BEHAVIOUR
// - Reset (rst=1 at posedge)
//   - clears the sync flops, tick prescaler, per-bit stability counters and all outputs
//   - no pulses in the reset cycle or the cycle after it
// - Sync: 2-flop synchroniser per bit gives sync[WIDTH-1:0] (2 clk latency).
// - Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for exactly one cycle when tick_cnt==TICK_DIV-1
//   - free-running, independent of the inputs
// - Per bit i, stab_cnt[i] of width clog2(STABLE_TICKS+1). Updates only on tick:
//   - sync[i]==sw_state[i]: stab_cnt[i]<=0 (glitch discarded).
//   - differ, stab_cnt[i]==STABLE_TICKS-1:
//     - sw_state[i]<=sync[i] and stab_cnt[i]<=0
//     - sw_rise[i] or sw_fall[i] <=1 on the same edge
//   - differ, otherwise: stab_cnt[i]++.
//   - Not on tick: stab_cnt and sw_state hold; sw_rise and sw_fall <=0.
// - Pulses are high in exactly the first cycle sw_state shows the new value.
// - Latency from a clean input edge to sw_state:
//   - at most 2 + TICK_DIV*STABLE_TICKS cycles
//   - at least 2 + (STABLE_TICKS-1)*TICK_DIV + 1 cycles
// - Bits are independent. Simultaneous acceptances raise several pulse bits in one cycle.
// - event_count:
//   - clear_count=1: <=0. Clear has priority over a same-cycle rise.
//   - Else, if |sw_rise: +1, saturating at 2^COUNT_W-1 (no wrap).
//   - Falls never count.
// - Inputs held at 1 through reset are accepted as a normal rise after reset
//   (rise pulse, event_count increments).
// - rst mid-debounce discards partial stab_cnt. No pulse is produced for that activity.
// TESTING (TICK_DIV=4, STABLE_TICKS=3, COUNT_W=4)
// 1. Reset with sw_in=0 -> sw_state, sw_rise, sw_fall, any_change and event_count all 0,
//    held 0 for 50 cycles.
// 2. sw_in[0] 0->1 held -> sw_state[0]=1 within 14 cycles; sw_rise[0] and any_change
//    for 1 cycle; event_count=1.
// 3. sw_in[1] toggles every 5 clk for 40 clk, then stays 0 -> sw_state[1] stays 0 and
//    no pulses occur.
// 4. Release sw_in[0] -> sw_fall[0] 1 cycle; event_count unchanged at 1.
// 5. sw_in[2], sw_in[3] rise in the same cycle -> sw_rise=8'h0C in one cycle;
//    event_count +1 only.
// 6. Boundaries:
//    - 16 clean presses -> event_count saturates at 15
//    - clear_count on a rise cycle -> 0
//    - rst 5 cycles into a debounce -> all 0, no pulse

Source files
------------

// File: rtl/switch_debounce.sv
// Synchronises and debounces WIDTH board inputs, producing clean levels,
// one-cycle rise/fall pulses per bit and a saturating count of rise cycles.
module switch_debounce #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw_in,
  input  logic               clear_count,
  output logic [WIDTH-1:0]   sw_state,
  output logic [WIDTH-1:0]   sw_rise,
  output logic [WIDTH-1:0]   sw_fall,
  output logic               any_change,
  output logic [COUNT_W-1:0] event_count
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]      STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] synced;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [SW-1:0]    stab_cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= sw_in;
      synced <= meta;
    end
  end

  // Free-running prescaler; debounce decisions happen only on its wrap cycle.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_state <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          // Any tick agreeing with the accepted level restarts the run.
          if (synced[i] == sw_state[i]) begin
            stab_cnt[i] <= '0;
          end else if (stab_cnt[i] == STAB_LAST) begin
            sw_state[i] <= synced[i];
            stab_cnt[i] <= '0;
            sw_rise[i]  <= synced[i];
            sw_fall[i]  <= ~synced[i];
          end else begin
            stab_cnt[i] <= stab_cnt[i] + SW'(1);
          end
        end
      end
    end
  end

  assign any_change = |(sw_rise | sw_fall);

  always_ff @(posedge clk) begin
    if (rst || clear_count) begin
      event_count <= '0;
    end else if ((|sw_rise) && (event_count != COUNT_MAX)) begin
      event_count <= event_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed scoreboard bench for switch_debounce: each accepted edge is
// queued when driven and compared when the debounced pulse appears.
module tb_switch_debounce;

  localparam int WIDTH        = 8;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int COUNT_W      = 4;
  localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;
  localparam int LAT_MAX      = 2 + TICK_DIV * STABLE_TICKS;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear_count;
  logic [WIDTH-1:0]   sw_in;
  logic [WIDTH-1:0]   sw_state;
  logic [WIDTH-1:0]   sw_rise;
  logic [WIDTH-1:0]   sw_fall;
  logic               any_change;
  logic [COUNT_W-1:0] event_count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   state;
    logic [COUNT_W-1:0] count;
    bit                 clr;
  } exp_t;

  exp_t sb[$];

  logic [WIDTH-1:0]   model_state;
  logic [COUNT_W-1:0] model_count;

  switch_debounce #(
    .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .clear_count(clear_count),
    .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .any_change(any_change), .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Expected result of settling at 'value', computed from the model level/count.
  task automatic pushExpect(input logic [WIDTH-1:0] value, input bit clr);
    exp_t e;
    e.rise  = value & ~model_state;
    e.fall  = ~value & model_state;
    e.state = value;
    if (e.rise != '0 && model_count != '1) model_count = model_count + 1'b1;
    if (clr) model_count = '0;
    e.count = model_count;
    e.clr   = clr;
    model_state = value;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] value, input bit clr);
    @(negedge clk);
    sw_in = value;
    pushExpect(value, clr);
  endtask

  task automatic checkOutput(input int lat_lo, input int lat_hi);
    exp_t e;
    int   cyc;
    bit   seen;
    compare("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < lat_hi + 4) begin
        @(negedge clk);
        cyc++;
        if ((sw_rise | sw_fall) != '0) seen = 1'b1;
      end
      compare("pulse_seen", seen, 1);
      if (seen) begin
        compare("latency_ok", (cyc >= lat_lo) && (cyc <= lat_hi), 1);
        compare("rise", sw_rise, e.rise);
        compare("fall", sw_fall, e.fall);
        compare("any_change", any_change, 1);
        compare("state", sw_state, e.state);
        if (e.clr) clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        compare("pulse_width", {sw_rise, sw_fall, any_change}, 0);
        compare("event_count", event_count, e.count);
      end
    end
  endtask

  task automatic quietCheck(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compare("no_pulse", {sw_rise, sw_fall, any_change}, 0);
      compare("quiet_state", sw_state, model_state);
      compare("quiet_count", event_count, model_count);
    end
  endtask

  task automatic modelReset();
    model_state = '0;
    model_count = '0;
    sb.delete();
  endtask

  initial begin
    rst         = 1'b1;
    clear_count = 1'b0;
    sw_in       = '0;
    modelReset();

    // Reset with inputs low, then a long quiet window.
    repeat (3) @(negedge clk);
    compare("reset_outputs", {sw_state, sw_rise, sw_fall, any_change, event_count}, 0);
    rst = 1'b0;
    quietCheck(50);

    // Single clean press on bit 0.
    applyStimulus(8'h01, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);

    // Bounce on bit 1 shorter than the stability window must be rejected.
    for (int k = 0; k < 8; k++) begin
      sw_in[1] = ~sw_in[1];
      quietCheck(5);
    end
    quietCheck(20);

    // Release bit 0: fall pulse, count untouched.
    applyStimulus(8'h00, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);

    // Two bits accepted together count as one event.
    applyStimulus(8'h0C, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);
    applyStimulus(8'h00, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);

    // Sixteen presses drive the 4-bit counter into saturation.
    for (int p = 0; p < 16; p++) begin
      applyStimulus(8'h10, 1'b0);
      checkOutput(LAT_MIN, LAT_MAX);
      applyStimulus(8'h00, 1'b0);
      checkOutput(LAT_MIN, LAT_MAX);
    end
    compare("saturated", event_count, 15);

    // Reset five cycles into a debounce discards it without a pulse.
    @(negedge clk);
    sw_in = 8'h20;
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    sw_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    quietCheck(30);

    // Clear on the rise-pulse cycle beats the increment.
    applyStimulus(8'h10, 1'b1);
    checkOutput(LAT_MIN, LAT_MAX);
    applyStimulus(8'h00, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);

    // Input held high through reset is accepted as a fresh rise afterwards.
    @(negedge clk);
    rst   = 1'b1;
    sw_in = 8'h40;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    quietCheck(2);
    pushExpect(8'h40, 1'b0);
    checkOutput(8, 12);
    applyStimulus(8'h00, 1'b0);
    checkOutput(LAT_MIN, LAT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
